// File: rtl/dm_wait_bridge.sv
// Bridges the core's single-cycle data-memory strobes onto a variable-latency req/ack memory port.
// The optional BUSY timeout is compiled in when DM_TIMEOUT_EN is defined.
module dm_wait_bridge #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  dm_enable,
  input  logic                  dm_read,
  input  logic                  dm_write,
  input  logic [ADDR_WIDTH-1:0] dm_address,
  input  logic [DATA_WIDTH-1:0] dm_in,
  output logic [DATA_WIDTH-1:0] dm_out,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  bus_error
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Timeouts beyond the 8-bit counter range clamp to its saturation value.
  localparam logic [7:0] TIMEOUT_CNT = (TIMEOUT > 255) ? 8'hFF : 8'(TIMEOUT);
`ifdef DM_TIMEOUT_EN
  localparam logic ABORT_EN = 1'b1;
`else
  localparam logic ABORT_EN = 1'b0;
`endif

  logic [1:0]            state_reg, state_next;
  logic                  mem_req_reg, mem_req_next;
  logic                  mem_we_reg, mem_we_next;
  logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_WIDTH-1:0] mem_wdata_reg, mem_wdata_next;
  logic [DATA_WIDTH-1:0] dm_out_reg, dm_out_next;
  logic                  bus_error_reg, bus_error_next;
  logic [7:0]            wait_cnt_reg, wait_cnt_next;
  logic [7:0]            wait_inc;
  logic                  acc;
  logic                  abort;

  assign acc      = dm_enable & (dm_read | dm_write);
  assign wait_inc = (wait_cnt_reg == 8'hFF) ? 8'hFF : wait_cnt_reg + 8'd1;
  assign abort    = ABORT_EN & (wait_inc >= TIMEOUT_CNT);

  always_comb begin
    state_next     = state_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    dm_out_next    = dm_out_reg;
    bus_error_next = bus_error_reg;
    wait_cnt_next  = wait_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (acc) begin
          mem_req_next   = 1'b1;
          mem_we_next    = dm_write;
          mem_addr_next  = dm_address;
          mem_wdata_next = dm_in;
          wait_cnt_next  = 8'd0;
          state_next     = BUSY;
        end
      end
      BUSY: begin
        wait_cnt_next = wait_inc;
        // A completion on the timeout edge takes priority over the abort.
        if (mem_ack) begin
          mem_req_next = 1'b0;
          if (!mem_we_reg) dm_out_next = mem_rdata;
          state_next = DONE;
        end else if (abort) begin
          mem_req_next   = 1'b0;
          bus_error_next = 1'b1;
          if (!mem_we_reg) dm_out_next = DATA_WIDTH'(32'hDEADBEEF);
          state_next = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      dm_out_reg    <= '0;
      bus_error_reg <= 1'b0;
      wait_cnt_reg  <= 8'd0;
    end else begin
      state_reg     <= state_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      dm_out_reg    <= dm_out_next;
      bus_error_reg <= bus_error_next;
      wait_cnt_reg  <= wait_cnt_next;
    end
  end

  // The core's request is held off combinationally in the detect cycle and throughout BUSY.
  assign stall     = ((state_reg == IDLE) & acc) | (state_reg == BUSY);
  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign dm_out    = dm_out_reg;
  assign bus_error = bus_error_reg;

endmodule

// File: doc/dm_wait_bridge.md
Name: dm_wait_bridge

Overview:
- Sits between the core's data-memory port and a variable-latency data memory.
- Converts the core's single-cycle DM_read/DM_write strobes into a req/ack handshake.
- Asserts a stall back to the pipeline until the access completes.
- Registers read data so the memory-access stage sees stable data in its completion cycle.

Parameters:
- ADDR_WIDTH, 12, data-memory byte address width (matches core DM_address)
- DATA_WIDTH, 32, data word width
- TIMEOUT, 255, max BUSY cycles before abort (used only with DM_TIMEOUT_EN)

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- dm_enable  input  1  core DM enable; no access accepted when 0
- dm_read  input  1  core load request
- dm_write  input  1  core store request
- dm_address  input  ADDR_WIDTH  core access address
- dm_in  input  DATA_WIDTH  core store data
- dm_out  output  DATA_WIDTH  registered load data to core
- stall  output  1  hold pipeline while access is outstanding
- mem_req  output  1  memory request, registered
- mem_we  output  1  1 = write, 0 = read, registered
- mem_addr  output  ADDR_WIDTH  registered access address
- mem_wdata  output  DATA_WIDTH  registered store data
- mem_rdata  input  DATA_WIDTH  memory read data, valid with mem_ack
- mem_ack  input  1  memory completion strobe, one cycle
- bus_error  output  1  sticky timeout flag (0 unless DM_TIMEOUT_EN)

Behaviour:
- States: IDLE, BUSY, DONE. Reset (synchronous) forces IDLE and clears the following regardless of current state:
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
  - dm_out=0, bus_error=0, wait counter=0
- Access detect: acc = dm_enable & (dm_read | dm_write).
  - If dm_read and dm_write are both high, the access is a write.
- stall is combinational: stall = (state==IDLE & acc) | (state==BUSY). stall is 0 in DONE.
- IDLE:
  - On acc: latch dm_address, dm_in and mem_we=dm_write into the mem_* registers; set mem_req=1; go to BUSY.
  - mem_ack in IDLE is ignored.
- BUSY:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - Wait counter increments each cycle.
  - On mem_ack: mem_req=0 at the same edge. For a read, dm_out<=mem_rdata; for a write, dm_out is unchanged. Go to DONE.
- DONE:
  - Lasts exactly one cycle with stall=0, so the core advances.
  - The core's request still present this cycle belongs to the finished access and is ignored.
  - Go to IDLE unconditionally.
- Latency: with ack on the k-th BUSY cycle (k>=1), stall is high for k+1 cycles. Minimum access is 3 cycles (IDLE-detect, BUSY, DONE).
- Back-to-back accesses: the next request is accepted in the IDLE cycle following DONE.
- dm_out holds its last loaded value in all states except the read-completion edge.
- Reset mid-BUSY: mem_req drops at that edge. A late mem_ack afterwards is ignored in IDLE.
- Wait counter is 8 bits wide and saturates; it is cleared on entering BUSY.

Optional Feature:
- Macro: DM_TIMEOUT_EN
- Defined:
  - If the wait counter reaches TIMEOUT in BUSY with no mem_ack, the access aborts at that edge: mem_req=0, dm_out<=32'hDEADBEEF for reads (unchanged for writes), bus_error<=1 (sticky until reset), go to DONE.
  - mem_ack arriving on the same edge as the timeout wins; no error is flagged.
- Not defined: BUSY waits indefinitely, bus_error is tied 0, and TIMEOUT is unused.

Test Plan:
- Reset, then idle:
  - all mem_* outputs, dm_out and stall are 0
  - mem_ack pulse in IDLE changes nothing
- Read addr 12'h040, mem_ack one cycle after mem_req with mem_rdata=32'h1234_5678:
  - stall high 2 cycles, then dm_out=32'h12345678 in DONE
  - mem_req high exactly 1 cycle, mem_we=0
- Write addr 12'h100 data 32'hCAFEF00D, ack after 5 BUSY cycles:
  - mem_addr/mem_wdata/mem_we=1 stable all 5 cycles
  - stall high 6 cycles
  - dm_out unchanged
- dm_read and dm_write both high with dm_enable=1:
  - treated as write, mem_we=1
- Back-to-back read then write with immediate acks:
  - second mem_req rises 1 cycle after DONE
  - core request held during DONE does not start an extra access
- Reset asserted during BUSY:
  - IDLE next cycle, mem_req=0, late mem_ack ignored
- DM_TIMEOUT_EN with TIMEOUT=8, no ack:
  - abort after 8 BUSY cycles, dm_out=32'hDEADBEEF, bus_error=1 until reset
